// File: rtl/ttt_autoplayer.sv
// ============================================================================
// Module     : ttt_autoplayer
// Description: Automatic tic-tac-toe player. Scans a board snapshot one cell
//              per cycle and offers its best move on a valid/ready handshake.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_autoplayer #(
    parameter logic [1:0] EMPTY_CODE  = 2'd0,
    parameter logic [1:0] MARK_P0     = 2'd1,
    parameter logic [1:0] MARK_P1     = 2'd2,
    parameter bit         CENTRE_PREF = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        my_player,
    input  logic [17:0] board,
    input  logic        move_ready,
    output logic        move_valid,
    output logic [2:0]  move_x,
    output logic [2:0]  move_y,
    output logic        busy,
    output logic        no_move
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_OFFER = 2'd2
    } state_t;

    // Eight winning lines, three 4-bit cell indices each, line 0 in the LSBs.
    localparam logic [95:0] C_LINES = {12'h246, 12'h048, 12'h258, 12'h147,
                                       12'h036, 12'h678, 12'h345, 12'h012};
    localparam logic [3:0]  C_LAST  = 4'd8;

    state_t      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [17:0] snap_q, snap_d;
    logic        me_q, me_d;
    logic        found_q, found_d;
    logic [2:0]  rank_q, rank_d;
    logic [3:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic [2:0]  x_q, x_d;
    logic [2:0]  y_q, y_d;
    logic        no_move_q, no_move_d;

    logic [3:0]  w_kc;
    logic [1:0]  w_cell;
    logic [1:0]  w_own;
    logic [1:0]  w_opp;
    logic        w_win;
    logic        w_blk;
    logic [2:0]  w_rank;

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] c);
        return b[{c, 1'b0} +: 2];
    endfunction

    // True when marking cell k with m completes some line through k.
    function automatic logic completes(input logic [17:0] b, input logic [3:0] k,
                                       input logic [1:0] m);
        logic       r;
        logic [3:0] a0, a1, a2;
        r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a0 = C_LINES[i*12+8 +: 4];
            a1 = C_LINES[i*12+4 +: 4];
            a2 = C_LINES[i*12   +: 4];
            if ((k == a0) && (cell_at(b, a1) == m) && (cell_at(b, a2) == m)) r = 1'b1;
            if ((k == a1) && (cell_at(b, a0) == m) && (cell_at(b, a2) == m)) r = 1'b1;
            if ((k == a2) && (cell_at(b, a0) == m) && (cell_at(b, a1) == m)) r = 1'b1;
        end
        return r;
    endfunction

    assign w_kc   = (k_q > C_LAST) ? 4'd0 : k_q;
    assign w_cell = cell_at(snap_q, w_kc);
    assign w_own  = me_q ? MARK_P1 : MARK_P0;
    assign w_opp  = me_q ? MARK_P0 : MARK_P1;
    assign w_win  = completes(snap_q, w_kc, w_own);
    assign w_blk  = completes(snap_q, w_kc, w_opp);

    always_comb begin
        w_rank = 3'd0;
        if (w_win) begin
            w_rank = 3'd4;
        end else if (w_blk) begin
            w_rank = 3'd3;
        end else if (CENTRE_PREF) begin
            if (w_kc == 4'd4) begin
                w_rank = 3'd2;
            end else if ((w_kc == 4'd0) || (w_kc == 4'd2) || (w_kc == 4'd6) || (w_kc == 4'd8)) begin
                w_rank = 3'd1;
            end
        end
    end

    // SCAN runs k = 0..8 evaluating cells, then k = 9 as the decision cycle.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        snap_d    = snap_q;
        me_d      = me_q;
        found_d   = found_q;
        rank_d    = rank_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        x_d       = x_q;
        y_d       = y_q;
        no_move_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = board;
                    me_d    = my_player;
                    found_d = 1'b0;
                    rank_d  = 3'd0;
                    idx_d   = 4'd0;
                    k_d     = 4'd0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (k_q <= C_LAST) begin
                    k_d = k_q + 4'd1;
                    if ((w_cell == EMPTY_CODE) && (!found_q || (w_rank > rank_q))) begin
                        found_d = 1'b1;
                        rank_d  = w_rank;
                        idx_d   = k_q;
                    end
                end else if (found_q) begin
                    x_d     = 3'(idx_q % 4'd3);
                    y_d     = 3'(idx_q / 4'd3);
                    valid_d = 1'b1;
                    state_d = S_OFFER;
                end else begin
                    no_move_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_OFFER: begin
                if (move_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= 4'd0;
            snap_q    <= 18'd0;
            me_q      <= 1'b0;
            found_q   <= 1'b0;
            rank_q    <= 3'd0;
            idx_q     <= 4'd0;
            valid_q   <= 1'b0;
            x_q       <= 3'd0;
            y_q       <= 3'd0;
            no_move_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            snap_q    <= snap_d;
            me_q      <= me_d;
            found_q   <= found_d;
            rank_q    <= rank_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            no_move_q <= no_move_d;
        end
    end

    assign move_valid = valid_q;
    assign move_x     = x_q;
    assign move_y     = y_q;
    assign no_move    = no_move_q;
    assign busy       = (state_q == S_SCAN) || (state_q == S_OFFER);

endmodule

`default_nettype wire

// File: tb/tb_ttt_autoplayer.sv
// ============================================================================
// Module     : tb_ttt_autoplayer
// Description: Scoreboard bench for ttt_autoplayer, centre-preferring and
//              raster-order instances driven in parallel.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ttt_autoplayer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        my_player;
    logic [17:0] board;
    logic        move_ready;
    logic        v1, nm1, b1, v2, nm2, b2;
    logic [2:0]  x1, y1, x2, y2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic       nm;
        logic [2:0] x1, y1, x2, y2;
        int         t;
    } exp_t;

    exp_t q[$];

    ttt_autoplayer u_dut1 (
        .clk(clk), .reset(reset), .start(start), .my_player(my_player),
        .board(board), .move_ready(move_ready), .move_valid(v1),
        .move_x(x1), .move_y(y1), .busy(b1), .no_move(nm1)
    );

    ttt_autoplayer #(.CENTRE_PREF(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .my_player(my_player),
        .board(board), .move_ready(move_ready), .move_valid(v2),
        .move_x(x2), .move_y(y2), .busy(b2), .no_move(nm2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Hex digit k of h is the code of cell k (digit 0 rightmost).
    function automatic logic [17:0] mk(input logic [35:0] h);
        logic [17:0] b;
        for (int k = 0; k < 9; k++) b[2*k +: 2] = h[4*k +: 2];
        return b;
    endfunction

    // Monitor: pops an expectation whenever a move or no_move appears.
    initial begin
        exp_t       e;
        logic       pv1, pv2, pn1;
        logic [2:0] hx1, hy1, hx2, hy2;
        pv1 = 1'b0; pv2 = 1'b0; pn1 = 1'b0;
        hx1 = 3'd0; hy1 = 3'd0; hx2 = 3'd0; hy2 = 3'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ((v1 && !pv1) || nm1) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("latency", cyc, e.t);
                        chk("no_move", nm1, e.nm);
                        chk("no_move_dut2", nm2, e.nm);
                        if (!e.nm) begin
                            chk("move_x", x1, e.x1);
                            chk("move_y", y1, e.y1);
                            chk("valid_dut2", v2, 1);
                            chk("move_x_dut2", x2, e.x2);
                            chk("move_y_dut2", y2, e.y2);
                        end else begin
                            chk("valid_with_no_move", v1, 0);
                        end
                    end
                end else if ((v2 && !pv2) || nm2) begin
                    chk("dut2_unexpected_output", 1, 0);
                end
                if (nm1 && pn1) chk("no_move_width", 2, 1);
                if (v1 && pv1) begin
                    chk("hold_x", x1, hx1);
                    chk("hold_y", y1, hy1);
                end
                if (v2 && pv2) begin
                    chk("hold_x_dut2", x2, hx2);
                    chk("hold_y_dut2", y2, hy2);
                end
                pv1 = v1; pv2 = v2; pn1 = nm1;
            end else begin
                pv1 = 1'b0; pv2 = 1'b0; pn1 = 1'b0;
            end
            hx1 = x1; hy1 = y1; hx2 = x2; hy2 = y2;
        end
    end

    task automatic do_move(input logic [17:0] bd, input logic me, input logic nm,
                           input logic [2:0] ex1, input logic [2:0] ey1,
                           input logic [2:0] ex2, input logic [2:0] ey2,
                           input int hold, input bit pre_ready, input bit disturb);
        exp_t e;
        int   n;
        @(negedge clk);
        board = bd; my_player = me; start = 1'b1; move_ready = pre_ready;
        @(posedge clk);
        #1;
        e.nm = nm; e.x1 = ex1; e.y1 = ey1; e.x2 = ex2; e.y2 = ey2; e.t = cyc + 10;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_scan", b1, 1);
        n = 0;
        while (!(v1 || nm1) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("wait_timeout", 0, 1);
            move_ready = 1'b0;
            return;
        end
        if (nm) begin
            @(negedge clk);
            chk("no_move_pulse_end", nm1, 0);
            chk("valid_after_no_move", v1, 0);
            chk("busy_after_no_move", b1, 0);
            move_ready = 1'b0;
            return;
        end
        if (!pre_ready) begin
            for (int i = 0; i < hold; i++) begin
                if (disturb && (i == 2)) begin
                    start = 1'b1;
                    board = ~bd;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            chk("valid_held", v1, 1);
            chk("busy_in_offer", b1, 1);
            move_ready = 1'b1;
        end
        @(negedge clk);
        chk("valid_drop", v1, 0);
        chk("valid_drop_dut2", v2, 0);
        chk("busy_after_handshake", b1, 0);
        move_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; my_player = 1'b0; board = 18'd0; move_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = ~start;
        end
        @(negedge clk);
        start = 1'b0;
        chk("reset_valid", v1, 0);
        chk("reset_x", x1, 0);
        chk("reset_y", y1, 0);
        chk("reset_busy", b1, 0);
        chk("reset_no_move", nm1, 0);
        chk("reset_busy_dut2", b2, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", b1, 0);

        do_move(mk(36'h000_000_000), 1'b0, 1'b0, 3'd1, 3'd1, 3'd0, 3'd0, 2, 1'b0, 1'b0);
        do_move(mk(36'h000_022_011), 1'b0, 1'b0, 3'd2, 3'd0, 3'd2, 3'd0, 0, 1'b1, 1'b0);
        do_move(mk(36'h011_020_000), 1'b1, 1'b0, 3'd2, 3'd2, 3'd2, 3'd2, 1, 1'b0, 1'b0);
        do_move(mk(36'h312_121_212), 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 0, 1'b0, 1'b0);
        do_move(mk(36'h000_020_003), 1'b0, 1'b0, 3'd2, 3'd0, 3'd1, 3'd0, 0, 1'b0, 1'b0);
        do_move(mk(36'h000_022_022), 1'b1, 1'b0, 3'd2, 3'd0, 3'd2, 3'd0, 0, 1'b0, 1'b0);
        do_move(mk(36'h000_000_000), 1'b1, 1'b0, 3'd1, 3'd1, 3'd0, 3'd0, 5, 1'b0, 1'b1);

        // Abort mid-scan: nothing may be offered afterwards.
        @(negedge clk);
        board = mk(36'h000_000_000); my_player = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_before_abort", b1, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", b1, 0);
        chk("abort_valid", v1, 0);
        chk("abort_no_move", nm1, 0);
        chk("abort_x", x1, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (14) @(negedge clk);
        chk("abort_stays_idle", b1, 0);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
